// File: rtl/adc_capture_if.sv
// Bus between the ADC capture front end and its consumer: raw sample in, calibrated stream out.
interface adc_capture_if #(
  parameter int unsigned DW = 10
) ();
  logic [DW-1:0]        i_data;
  logic                 cal_start;
  logic signed [DW-1:0] o_data;
  logic                 o_valid;
  logic [DW-1:0]        bias;
  logic                 cal_busy;
  logic                 cal_done;

  modport master (
    output i_data, cal_start,
    input  o_data, o_valid, bias, cal_busy, cal_done
  );

  modport slave (
    input  i_data, cal_start,
    output o_data, o_valid, bias, cal_busy, cal_done
  );
endinterface

// File: rtl/adc_capture.sv
// ADC capture: register, subtract calibrated bias, saturate, decimate; forwards ~clk to the ADC.
// ADC_CAPTURE_ODDR_EN selects an ODDR2 pad-registered adc_clk instead of a plain inverter.
module adc_capture #(
  parameter int unsigned   DW       = 10,
  parameter logic [DW-1:0] DC_BIAS  = 10'd380,
  parameter int unsigned   CAL_LOG2 = 10,
  parameter int unsigned   DECIM    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  adc_capture_if.slave bus,
  output logic         adc_clk,
  output logic         oe
);

  localparam int unsigned AccW  = DW + CAL_LOG2;
  localparam int unsigned DcntW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DcntW-1:0]  DcntMax = DcntW'(DECIM - 1);
  localparam logic signed [DW:0] SatMax = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [DW:0] SatMin = {2'b11, {(DW-1){1'b0}}};
  localparam logic [AccW:0]      RoundHalf = (AccW+1)'(1) << (CAL_LOG2 - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StLoad} state_e;

  logic [DW-1:0]        r_data;
  logic                 r_v1;
  logic [DcntW-1:0]     r_dcnt;
  logic signed [DW-1:0] r_odata;
  logic                 r_ovalid;
  state_e               r_state, w_state_d;
  logic [AccW-1:0]      r_acc, w_acc_d;
  logic [CAL_LOG2-1:0]  r_scnt, w_scnt_d;
  logic [DW-1:0]        r_bias, w_bias_d;
  logic                 w_busy, w_done;

  logic signed [DW:0]   w_diff;
  logic signed [DW-1:0] w_sat;
  logic [AccW:0]        w_round;
  logic [DW:0]          w_mean;
  logic [DW-1:0]        w_mean_sat;

  // Both operands zero-extended so the difference is exact in DW+1 signed bits.
  assign w_diff = $signed({1'b0, r_data}) - $signed({1'b0, r_bias});

  always_comb begin
    if (w_diff > SatMax) begin
      w_sat = SatMax[DW-1:0];
    end else if (w_diff < SatMin) begin
      w_sat = SatMin[DW-1:0];
    end else begin
      w_sat = w_diff[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_v1     <= 1'b0;
      r_dcnt   <= '0;
      r_odata  <= '0;
      r_ovalid <= 1'b0;
    end else begin
      r_data   <= bus.i_data;
      r_v1     <= 1'b1;
      r_ovalid <= 1'b0;
      if (r_v1) begin
        if (r_dcnt == DcntMax) begin
          r_dcnt   <= '0;
          r_odata  <= w_sat;
          r_ovalid <= 1'b1;
        end else begin
          r_dcnt <= r_dcnt + DcntW'(1);
        end
      end
    end
  end

  // Round half-up; the mean can only exceed DW bits through the rounding carry.
  assign w_round    = {1'b0, r_acc} + RoundHalf;
  assign w_mean     = w_round[AccW:CAL_LOG2];
  assign w_mean_sat = w_mean[DW] ? {DW{1'b1}} : w_mean[DW-1:0];

  always_comb begin
    w_state_d = r_state;
    w_acc_d   = r_acc;
    w_scnt_d  = r_scnt;
    w_bias_d  = r_bias;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.cal_start) begin
          w_state_d = StAccum;
          w_acc_d   = '0;
          w_scnt_d  = '0;
        end
      end
      StAccum: begin
        w_busy   = 1'b1;
        w_acc_d  = r_acc + {{CAL_LOG2{1'b0}}, r_data};
        w_scnt_d = r_scnt + CAL_LOG2'(1);
        if (r_scnt == {CAL_LOG2{1'b1}}) begin
          w_state_d = StLoad;
        end
      end
      StLoad: begin
        w_done    = 1'b1;
        w_bias_d  = w_mean_sat;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_acc   <= '0;
      r_scnt  <= '0;
      r_bias  <= DC_BIAS;
    end else begin
      r_state <= w_state_d;
      r_acc   <= w_acc_d;
      r_scnt  <= w_scnt_d;
      r_bias  <= w_bias_d;
    end
  end

  assign bus.o_data   = r_odata;
  assign bus.o_valid  = r_ovalid;
  assign bus.bias     = r_bias;
  assign bus.cal_busy = w_busy;
  assign bus.cal_done = w_done;
  assign oe           = 1'b0;

`ifdef ADC_CAPTURE_ODDR_EN
  logic w_clk_n;
  assign w_clk_n = ~clk;

  ODDR2 #(
    .DDR_ALIGNMENT("NONE"),
    .INIT         (1'b0),
    .SRTYPE       ("SYNC")
  ) u_oddr (
    .Q (adc_clk),
    .C0(w_clk_n),
    .C1(clk),
    .CE(1'b1),
    .D0(1'b1),
    .D1(1'b0),
    .R (1'b0),
    .S (1'b0)
  );
`else
  assign adc_clk = ~clk;
`endif

endmodule

// File: tb/tb_adc_capture.sv
// Drives three adc_capture configurations with a shared stimulus and checks them against a
// time-indexed reference model of sampling, decimation and block-average calibration.
module tb_adc_capture;

  logic clk;
  logic rst_n;
  logic adc_clk_a, adc_clk_b, adc_clk_c;
  logic oe_a, oe_b, oe_c;

  adc_capture_if #(.DW(10)) if_a ();
  adc_capture_if #(.DW(10)) if_b ();
  adc_capture_if #(.DW(10)) if_c ();

  adc_capture #(.DW(10), .DC_BIAS(10'd380), .CAL_LOG2(4), .DECIM(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a), .adc_clk(adc_clk_a), .oe(oe_a)
  );
  adc_capture #(.DW(10), .DC_BIAS(10'd380), .CAL_LOG2(4), .DECIM(4)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b), .adc_clk(adc_clk_b), .oe(oe_b)
  );
  adc_capture #(.DW(10), .DC_BIAS(10'd1000), .CAL_LOG2(3), .DECIM(1)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c), .adc_clk(adc_clk_c), .oe(oe_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Per-instance configuration and model state
  int cfg_bias[3]  = '{380, 380, 1000};
  int cfg_decim[3] = '{1, 4, 1};
  int cfg_log2[3]  = '{4, 4, 3};
  int m_bias[3];
  int m_od[3];
  int m_ov[3];
  int m_calt[3];
  int m_busy[3];
  int m_done[3];
  int n_busy[3];
  int n_done[3];
  int samp[4096];
  int k;

  function automatic int sat10(input int x);
    if (x > 511) return 511;
    if (x < -512) return -512;
    return x;
  endfunction

  task automatic chk(input string tag, input int i, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, i, obs, exp);
    end
  endtask

  // Edge k is the k-th edge since reset release; samp[k] is the sample taken at that edge.
  task automatic model_edge(input int d, input bit st, input bit rst);
    if (rst) begin
      k = 0;
      for (int i = 0; i < 3; i++) begin
        m_bias[i] = cfg_bias[i];
        m_od[i]   = 0;
        m_ov[i]   = 0;
        m_calt[i] = -1;
        m_busy[i] = 0;
        m_done[i] = 0;
      end
    end else begin
      k++;
      samp[k % 4096] = d;
      for (int i = 0; i < 3; i++) begin
        int n;
        n = 1 << cfg_log2[i];
        if (k >= 2 && ((k - 2) % cfg_decim[i]) == cfg_decim[i] - 1) begin
          m_ov[i] = 1;
          m_od[i] = sat10(samp[(k - 1) % 4096] - m_bias[i]);
        end else begin
          m_ov[i] = 0;
        end
        if (m_calt[i] < 0 && st) m_calt[i] = k;
        if (m_calt[i] >= 0 && k == m_calt[i] + n + 1) begin
          longint sum;
          int mean;
          sum = 0;
          for (int j = m_calt[i]; j < m_calt[i] + n; j++) sum += samp[j % 4096];
          mean = int'((sum + n / 2) / n);
          m_bias[i] = (mean > 1023) ? 1023 : mean;
          m_calt[i] = -1;
        end
        m_busy[i] = (m_calt[i] >= 0 && k <= m_calt[i] + n - 1) ? 1 : 0;
        m_done[i] = (m_calt[i] >= 0 && k == m_calt[i] + n) ? 1 : 0;
      end
    end
  endtask

  task automatic check_inst(input int i, input logic [9:0] od, input logic ov,
                            input logic [9:0] b, input logic busy, input logic done,
                            input logic aclk);
    chk("o_data", i, 32'($signed(od)), m_od[i]);
    chk("o_valid", i, 32'(ov), m_ov[i]);
    chk("bias", i, 32'(b), m_bias[i]);
    chk("cal_busy", i, 32'(busy), m_busy[i]);
    chk("cal_done", i, 32'(done), m_done[i]);
    chk("adc_clk", i, 32'(aclk), 32'(!clk));
    if (busy === 1'b1) n_busy[i]++;
    if (done === 1'b1) n_done[i]++;
  endtask

  task automatic step(input int d, input bit st, input bit rst);
    if_a.i_data = 10'(d);
    if_b.i_data = 10'(d);
    if_c.i_data = 10'(d);
    if_a.cal_start = st;
    if_b.cal_start = st;
    if_c.cal_start = st;
    rst_n = ~rst;
    @(posedge clk);
    #1;
    model_edge(d, st, rst);
    check_inst(0, if_a.o_data, if_a.o_valid, if_a.bias, if_a.cal_busy, if_a.cal_done, adc_clk_a);
    check_inst(1, if_b.o_data, if_b.o_valid, if_b.bias, if_b.cal_busy, if_b.cal_done, adc_clk_b);
    check_inst(2, if_c.o_data, if_c.o_valid, if_c.bias, if_c.cal_busy, if_c.cal_done, adc_clk_c);
    chk("oe", 0, 32'(oe_a | oe_b | oe_c), 0);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin
      n_busy[i] = 0;
      n_done[i] = 0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    k = 0;
    clear_counts();

    // Reset state
    step(0, 0, 1);
    step(0, 0, 1);

    // Input equal to bias: zero output, continuous valid on the DECIM=1 instance
    repeat (6) step(380, 0, 0);
    chk("t1_zero", 0, 32'($signed(if_a.o_data)), 0);
    chk("t1_valid", 0, 32'(if_a.o_valid), 1);

    // Saturation on both rails
    step(1023, 0, 0);
    step(0, 0, 0);
    chk("t2_pos_sat", 0, 32'($signed(if_a.o_data)), 511);
    chk("t2_c_pos", 2, 32'($signed(if_c.o_data)), 23);
    step(0, 0, 0);
    chk("t2_neg", 0, 32'($signed(if_a.o_data)), -380);
    chk("t3_neg_sat", 2, 32'($signed(if_c.o_data)), -512);
    step(600, 0, 0);
    step(600, 0, 0);
    chk("t3_c_600", 2, 32'($signed(if_c.o_data)), -400);

    // Calibration on a constant 400 input
    clear_counts();
    step(400, 1, 0);
    repeat (30) step(400, 0, 0);
    chk("t4_busy_len", 0, n_busy[0], 16);
    chk("t4_done_cnt", 0, n_done[0], 1);
    chk("t4_bias", 0, 32'(if_a.bias), 400);
    chk("t4_after", 0, 32'($signed(if_a.o_data)), 0);
    chk("t4_c_busy_len", 2, n_busy[2], 8);
    chk("t4_c_bias", 2, 32'(if_c.bias), 400);

    // Ramp through the decimating instance; second request lands during ACCUM
    step(380, 0, 1);
    clear_counts();
    for (int v = 380; v <= 400; v++) step(v, (v == 382) || (v == 388), 0);
    repeat (4) step(400, 0, 0);
    chk("t5_one_cal", 1, n_done[1], 1);
    chk("t5_busy_len", 1, n_busy[1], 16);

    // Reset aborts a calibration halfway through
    step(500, 0, 1);
    clear_counts();
    step(500, 1, 0);
    repeat (8) step(500, 0, 0);
    step(500, 0, 1);
    chk("t6_busy", 0, 32'(if_a.cal_busy), 0);
    chk("t6_bias", 0, 32'(if_a.bias), 380);
    chk("t6_no_done", 0, n_done[0], 0);
    step(450, 1, 0);
    repeat (20) step(450, 0, 0);
    chk("t6_redo_bias", 0, 32'(if_a.bias), 450);
    chk("t6_redo_done", 0, n_done[0], 1);

    // Randomized traffic with sporadic calibration requests
    repeat (300) step(int'($urandom_range(0, 1023)), ($urandom_range(0, 19) == 0), 0);

    @(negedge clk);
    #1;
    chk("adc_clk_low_phase", 0, 32'(adc_clk_a), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
